crc_share_ctrl: RTL and testbench
=================================

Name: crc_share_ctrl

Overview:
- Sequencer and round-robin arbiter sharing one keyed CRC engine (crc_top-style: enable / data_in[7:0] / key[15:0] in, crc_done / crc[7:0] out) between two byte-stream requesters, channel 0 = TX framer and channel 1 = RX deframer.
- Grants the engine one whole frame at a time, clears it, loads the channel key and streams bytes.
- Waits for crc_done, then returns the CRC to the owning channel.
- Sits between the serial framers and the CRC datapath in the security wrapper.

Parameters:
- MAX_LEN, 64, maximum bytes per frame; the frame is force-terminated when this is reached.
- DONE_TIMEOUT, 32, cycles to wait for eng_crc_done after the last byte before flagging an error.
- CNT_W, 7, width of the byte counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-channel byte valid (bit i = channel i).
- req_data  input  16  per-channel byte; [7:0] = ch0, [15:8] = ch1.
- req_last  input  2  per-channel last-byte-of-frame marker, qualified by req_valid.
- req_ready  output  2  per-channel byte accepted (byte transfers when valid & ready).
- key0  input  16  CRC key for channel 0.
- key1  input  16  CRC key for channel 1.
- res_valid  output  2  one-cycle pulse on the owning channel's bit when a result is ready.
- res_crc  output  8  CRC result, valid with res_valid and held until the next result.
- res_err  output  1  result is a timeout; valid with res_valid.
- res_trunc  output  1  frame was cut at MAX_LEN; valid with res_valid.
- busy  output  1  high in every state except IDLE.
- eng_rst_n  output  1  active-low clear to the engine; low for exactly one cycle per frame.
- eng_enable  output  1  engine byte strobe.
- eng_data  output  8  engine byte.
- eng_key  output  16  engine key, stable for the whole frame.
- eng_crc_done  input  1  engine completion.
- eng_crc  input  8  engine result.

Behaviour:
- Reset values: state IDLE, last_grant = 1 (so ch0 wins first), grant = 0, count = 0, all req_ready = 0, res_valid = 0, res_crc = 0x00, res_err = 0, res_trunc = 0, busy = 0, eng_rst_n = 1, eng_enable = 0, eng_data = 0x00, eng_key = 0x0000.
- IDLE
  - If neither req_valid bit is set, stay in IDLE.
  - If exactly one bit is set, grant that channel.
  - If both are set, grant the channel that is not last_grant.
  - On a grant: register grant, update last_grant, go to CLEAR.
  - No byte is accepted in IDLE.
- CLEAR (1 cycle)
  - eng_rst_n = 0.
  - eng_key = key of the granted channel, registered here and held until the next CLEAR.
  - count is cleared.
  - Next state: STREAM.
- STREAM
  - req_ready[grant] = 1; the other bit is 0.
  - eng_enable = req_valid[grant], combinational; eng_data = that channel's byte when enabled, otherwise 0x00.
  - Each accepted byte increments count.
  - On an accepted byte with req_last, go to WAIT_DONE with trunc = 0.
  - On an accepted byte that makes count == MAX_LEN without req_last, go to WAIT_DONE with trunc = 1. The requester's remaining bytes then start a new frame via normal arbitration.
  - An idle cycle (valid = 0) holds state.
  - eng_crc_done is ignored in STREAM.
- WAIT_DONE
  - eng_enable = 0; the wait counter starts at 0.
  - On eng_crc_done = 1: capture eng_crc into res_crc, set err = 0, go to RESULT.
  - If DONE_TIMEOUT cycles pass without eng_crc_done: res_crc = 0x00, err = 1, go to RESULT.
  - If done and timeout land in the same cycle, done wins.
- RESULT (1 cycle)
  - res_valid[grant] = 1, res_err = err, res_trunc = trunc.
  - Next state: IDLE, so arbitration restarts the following cycle.
- Flags: res_err and res_trunc hold their values until the next RESULT.
- Fairness: with both channels continuously requesting, frames alternate ch0, ch1, ch0, …
- Latency
  - Grant to first possible byte: 2 cycles (IDLE to CLEAR, CLEAR to STREAM).
  - eng_crc_done to res_valid: 1 cycle.
- Reset mid-operation: asynchronous return to IDLE with all reset values. The partial frame is discarded and no res_valid is issued.
- A req_last asserted while not granted has no effect.

Test Plan:
- Single frame: ch0 sends 48 65 6C 6C 6F 31 32 33 (last on 0x33), key0 = 0xBEEF; a stub engine raises done 3 cycles after enable drops with crc = 0xA5.
  - Required: eng_rst_n low one cycle; eng_key = 0xBEEF; 8 eng_enable strobes with matching eng_data; res_valid = 2'b01 with res_crc = 0xA5, res_err = 0, res_trunc = 0.
- Contention: both channels request from the same cycle, ch1 key1 = 0x1234.
  - Required: ch0 is served first, then ch1 with eng_key = 0x1234.
  - Required: req_ready[1] stays 0 during the ch0 frame.
  - Required: results arrive as res_valid 01, then 10.
- Back-pressure gaps: ch1 drops valid for 3 cycles mid-frame.
  - Required: no eng_enable during the gaps, count unchanged, result still correct.
- Truncation: with MAX_LEN = 4, ch0 streams 6 bytes with no last.
  - Required: first frame of 4 bytes ends with res_trunc = 1; the remaining 2 bytes form a second frame after re-arbitration.
- Timeout: the stub never raises done.
  - Required: exactly DONE_TIMEOUT = 32 cycles after the last byte, res_valid with res_err = 1 and res_crc = 0x00.
  - Also check that done and timeout in the same cycle gives res_err = 0.
- Reset mid-frame: reset_n low after the 3rd byte.
  - Required: all outputs at reset values immediately, no res_valid.
  - Required: after release, ch0 is granted first.

Source files
------------

// File: rtl/crc_share_ctrl_if.sv
// crc_share_ctrl_if: request/result bundle between the two byte-stream requesters and crc_share_ctrl
//   req_valid[1:0]  per-channel byte valid (bit i = channel i)
//   req_data[15:0]  per-channel byte, [7:0] = ch0, [15:8] = ch1
//   req_last[1:0]   per-channel last-byte marker, qualified by req_valid
//   req_ready[1:0]  per-channel byte accepted
//   res_valid[1:0]  one-cycle result pulse on the owning channel's bit
//   res_crc[7:0]    CRC result, held until the next result
//   res_err         result is a timeout
//   res_trunc       frame was cut at MAX_LEN
interface crc_share_ctrl_if;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  res_valid;
    logic [7:0]  res_crc;
    logic        res_err;
    logic        res_trunc;
    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, res_valid, res_crc, res_err, res_trunc
    );
    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, res_valid, res_crc, res_err, res_trunc
    );
endinterface

// File: rtl/crc_share_ctrl.sv
// crc_share_ctrl: round-robin sequencer sharing one keyed CRC engine between two byte-stream channels
//   clk, reset_n         clock and asynchronous active-low reset
//   bus                  requester bundle (crc_share_ctrl_if.slave)
//   key0, key1           per-channel CRC keys
//   busy                 high outside IDLE
//   eng_rst_n            one-cycle active-low engine clear per frame
//   eng_enable/eng_data  engine byte strobe and byte
//   eng_key              engine key, stable for the whole frame
//   eng_crc_done/eng_crc engine completion and result
module crc_share_ctrl #(
    parameter int MAX_LEN      = 64,
    parameter int DONE_TIMEOUT = 32,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    crc_share_ctrl_if.slave  bus,
    input  logic [15:0]      key0,
    input  logic [15:0]      key1,
    output logic             busy,
    output logic             eng_rst_n,
    output logic             eng_enable,
    output logic [7:0]       eng_data,
    output logic [15:0]      eng_key,
    input  logic             eng_crc_done,
    input  logic [7:0]       eng_crc
);
    localparam int WT_W = $clog2(DONE_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT_DONE, RESULT} state_t;
    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             trunc_q, trunc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WT_W-1:0]  wait_q, wait_d;
    logic [15:0]      key_q, key_d;
    logic [7:0]       res_crc_q, res_crc_d;
    logic             res_err_q, res_err_d;
    logic             res_trunc_q, res_trunc_d;
    logic [7:0]       req_byte;
    logic             accept;

    assign req_byte = grant_q ? bus.req_data[15:8] : bus.req_data[7:0];
    assign accept   = (state_q == STREAM) && bus.req_valid[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        trunc_d      = trunc_q;
        count_d      = count_q;
        wait_d       = wait_q;
        key_d        = key_q;
        res_crc_d    = res_crc_q;
        res_err_d    = res_err_q;
        res_trunc_d  = res_trunc_q;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                // both requesting: the channel not served last time wins
                grant_d      = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
                last_grant_d = grant_d;
                key_d        = grant_d ? key1 : key0;
                state_d      = CLEAR;
            end
            CLEAR: begin
                count_d = '0;
                state_d = STREAM;
            end
            STREAM: begin
                wait_d = '0;
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (bus.req_last[grant_q]) begin
                        trunc_d = 1'b0;
                        state_d = WAIT_DONE;
                    end else if (count_q + 1'b1 == CNT_W'(MAX_LEN)) begin
                        trunc_d = 1'b1;
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // done takes priority over a timeout landing in the same cycle
                if (eng_crc_done || wait_q == WT_W'(DONE_TIMEOUT - 1)) begin
                    res_crc_d   = eng_crc_done ? eng_crc : 8'h00;
                    res_err_d   = ~eng_crc_done;
                    res_trunc_d = trunc_q;
                    state_d     = RESULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            trunc_q      <= 1'b0;
            count_q      <= '0;
            wait_q       <= '0;
            key_q        <= 16'h0000;
            res_crc_q    <= 8'h00;
            res_err_q    <= 1'b0;
            res_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            trunc_q      <= trunc_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            key_q        <= key_d;
            res_crc_q    <= res_crc_d;
            res_err_q    <= res_err_d;
            res_trunc_q  <= res_trunc_d;
        end
    end

    assign bus.req_ready = (state_q == STREAM) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.res_valid = (state_q == RESULT) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.res_crc   = res_crc_q;
    assign bus.res_err   = res_err_q;
    assign bus.res_trunc = res_trunc_q;
    assign busy          = state_q != IDLE;
    assign eng_rst_n     = state_q != CLEAR;
    assign eng_enable    = accept;
    assign eng_data      = accept ? req_byte : 8'h00;
    assign eng_key       = key_q;
endmodule

// File: tb/tb_crc_share_ctrl.sv
// tb_crc_share_ctrl: directed scoreboard bench for crc_share_ctrl with stub CRC engines
module tb_crc_share_ctrl;
    typedef struct packed { logic gap; logic last; logic [7:0] d; } rb_t;
    typedef struct packed { logic ch; logic [15:0] key; logic [7:0] d; } eb_t;
    typedef struct packed { logic [1:0] rv; logic [7:0] crc; logic err; logic trunc; int lat; } er_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] key0 = 16'hBEEF, key1 = 16'h1234;
    logic        busy0, rstn0, en0, done0, arm0;
    logic        busy1, rstn1, en1, done1, arm1;
    logic [7:0]  data0, data1;
    logic [7:0]  crc_in0 = 8'hA5, crc_in1 = 8'h5A;
    logic [15:0] ekey0, ekey1;
    int          dly0 = 3, dly1 = 3, scnt0, scnt1;

    rb_t  rq[2][2][$];
    eb_t  bq[2][$];
    er_t  resq[2][$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    int   last_acc[2], nclr[2], exp_clr[2];
    logic prev_clr[2];
    logic [7:0] hello[8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h31, 8'h32, 8'h33};

    crc_share_ctrl_if b0();
    crc_share_ctrl_if b1();

    crc_share_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .bus(b0), .key0(key0), .key1(key1), .busy(busy0),
        .eng_rst_n(rstn0), .eng_enable(en0), .eng_data(data0), .eng_key(ekey0),
        .eng_crc_done(done0), .eng_crc(crc_in0)
    );

    crc_share_ctrl #(.MAX_LEN(4)) u_trn (
        .clk(clk), .reset_n(reset_n), .bus(b1), .key0(key0), .key1(key1), .busy(busy1),
        .eng_rst_n(rstn1), .eng_enable(en1), .eng_data(data1), .eng_key(ekey1),
        .eng_crc_done(done1), .eng_crc(crc_in1)
    );

    always #5 clk = ~clk;

    // stub engines: done pulses dly cycles after the last enable (dly < 0: never)
    assign done0 = arm0 && dly0 >= 0 && scnt0 == dly0;
    assign done1 = arm1 && dly1 >= 0 && scnt1 == dly1;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin arm0 <= 1'b0; scnt0 <= 0; end
        else if (!rstn0) arm0 <= 1'b0;
        else if (en0) begin arm0 <= 1'b1; scnt0 <= 0; end
        else if (arm0) begin scnt0 <= scnt0 + 1; if (done0) arm0 <= 1'b0; end

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin arm1 <= 1'b0; scnt1 <= 0; end
        else if (!rstn1) arm1 <= 1'b0;
        else if (en1) begin arm1 <= 1'b1; scnt1 <= 0; end
        else if (arm1) begin scnt1 <= scnt1 + 1; if (done1) arm1 <= 1'b0; end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int d, input int ch, input logic [7:0] v, input logic last, input bit exp_it);
        rq[d][ch].push_back('{gap: 1'b0, last: last, d: v});
        if (exp_it) bq[d].push_back('{ch: ch[0], key: (ch != 0 ? key1 : key0), d: v});
    endtask

    task automatic frame(input int d, input int ch, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) push_byte(d, ch, base + 8'(i), i == n - 1, 1'b1);
    endtask

    task automatic push_res(input int d, input int ch, input logic [7:0] crc, input logic err, input logic trunc, input int lat);
        resq[d].push_back('{rv: (ch != 0 ? 2'b10 : 2'b01), crc: crc, err: err, trunc: trunc, lat: lat});
        exp_clr[d]++;
    endtask

    function automatic rb_t front(input int d, input int ch);
        if (rq[d][ch].size() > 0) return rq[d][ch][0];
        return '{gap: 1'b1, last: 1'b0, d: 8'h00};
    endfunction

    function automatic bit pending();
        bit p = busy0 | busy1;
        for (int d = 0; d < 2; d++) begin
            p |= bq[d].size() > 0 || resq[d].size() > 0;
            for (int c = 0; c < 2; c++) p |= rq[d][c].size() > 0;
        end
        return p;
    endfunction

    task automatic drive();
        rb_t f[2][2];
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) f[d][c] = front(d, c);
        b0.req_valid = {~f[0][1].gap, ~f[0][0].gap};
        b0.req_data  = {f[0][1].d, f[0][0].d};
        b0.req_last  = {f[0][1].last, f[0][0].last};
        b1.req_valid = {~f[1][1].gap, ~f[1][0].gap};
        b1.req_data  = {f[1][1].d, f[1][0].d};
        b1.req_last  = {f[1][1].last, f[1][0].last};
    endtask

    task automatic chk(input int d, input logic en, input logic [7:0] data, input logic [15:0] key,
                       input logic [1:0] rdy, input logic [1:0] rv, input logic [7:0] crc,
                       input logic err, input logic trunc, input logic rstn);
        eb_t e;
        er_t r;
        if (en) begin
            if (bq[d].size() == 0) check($sformatf("d%0d_extra_byte", d), 64'(en), 64'(0));
            else begin
                e = bq[d].pop_front();
                check($sformatf("d%0d_eng_data", d), 64'(data), 64'(e.d));
                check($sformatf("d%0d_eng_key", d), 64'(key), 64'(e.key));
                check($sformatf("d%0d_req_ready", d), 64'(rdy), 64'(e.ch ? 2'b10 : 2'b01));
            end
        end else check($sformatf("d%0d_eng_data_idle", d), 64'(data), 64'(0));
        if (rv != 2'b00) begin
            if (resq[d].size() == 0) check($sformatf("d%0d_extra_res", d), 64'(rv), 64'(0));
            else begin
                r = resq[d].pop_front();
                check($sformatf("d%0d_res_valid", d), 64'(rv), 64'(r.rv));
                check($sformatf("d%0d_res_crc", d), 64'(crc), 64'(r.crc));
                check($sformatf("d%0d_res_err", d), 64'(err), 64'(r.err));
                check($sformatf("d%0d_res_trunc", d), 64'(trunc), 64'(r.trunc));
                check($sformatf("d%0d_res_lat", d), 64'(cyc - last_acc[d]), 64'(r.lat));
            end
        end
        if (!rstn) begin
            check($sformatf("d%0d_clr_pulse", d), 64'(prev_clr[d]), 64'(0));
            nclr[d]++;
        end
        prev_clr[d] = !rstn;
    endtask

    task automatic tick();
        logic [1:0] a[2];
        drive();
        #2;
        chk(0, en0, data0, ekey0, b0.req_ready, b0.res_valid, b0.res_crc, b0.res_err, b0.res_trunc, rstn0);
        chk(1, en1, data1, ekey1, b1.req_ready, b1.res_valid, b1.res_crc, b1.res_err, b1.res_trunc, rstn1);
        a[0] = b0.req_valid & b0.req_ready;
        a[1] = b1.req_valid & b1.req_ready;
        for (int d = 0; d < 2; d++) if (|a[d]) last_acc[d] = cyc + 1;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                if (rq[d][c].size() > 0 && (a[d][c] || rq[d][c][0].gap)) void'(rq[d][c].pop_front());
        #1;
    endtask

    task automatic run_idle(input int max);
        int i = 0;
        while (i < max && pending()) begin tick(); i++; end
        check("drain", 64'(pending()), 64'(0));
    endtask

    task automatic chk_rst(input string tag, input logic [1:0] rdy, input logic [1:0] rv, input logic [7:0] crc,
                           input logic err, input logic trunc, input logic bz, input logic rn, input logic en,
                           input logic [7:0] dat, input logic [15:0] key);
        check(tag, 64'({rdy, rv, crc, err, trunc, bz, rn, en, dat, key}),
              64'({2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000}));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin last_acc[d] = 0; nclr[d] = 0; exp_clr[d] = 0; prev_clr[d] = 1'b0; end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_rst("reset_d0", b0.req_ready, b0.res_valid, b0.res_crc, b0.res_err, b0.res_trunc, busy0, rstn0, en0, data0, ekey0);
        chk_rst("reset_d1", b1.req_ready, b1.res_valid, b1.res_crc, b1.res_err, b1.res_trunc, busy1, rstn1, en1, data1, ekey1);
        reset_n = 1'b1;
        // contention from reset: ch0 first, ch1's held last has no effect meanwhile
        crc_in0 = 8'h3C;
        frame(0, 0, 8'h10, 4);
        frame(0, 1, 8'hC1, 1);
        push_res(0, 0, 8'h3C, 1'b0, 1'b0, 4);
        push_res(0, 1, 8'h3C, 1'b0, 1'b0, 4);
        run_idle(100);
        // single frame "Hello123"
        crc_in0 = 8'hA5;
        for (int i = 0; i < 8; i++) push_byte(0, 0, hello[i], i == 7, 1'b1);
        push_res(0, 0, 8'hA5, 1'b0, 1'b0, 4);
        run_idle(100);
        // fairness: ch0 served last, so ch1 goes first
        crc_in0 = 8'hC3;
        frame(0, 1, 8'h21, 2);
        frame(0, 0, 8'h01, 3);
        push_res(0, 1, 8'hC3, 1'b0, 1'b0, 4);
        push_res(0, 0, 8'hC3, 1'b0, 1'b0, 4);
        run_idle(100);
        // ch1 with a 3-cycle gap mid-frame; stub done during STREAM must be ignored
        crc_in0 = 8'h96;
        push_byte(0, 1, 8'h31, 1'b0, 1'b1);
        push_byte(0, 1, 8'h32, 1'b0, 1'b1);
        repeat (3) rq[0][1].push_back('{gap: 1'b1, last: 1'b0, d: 8'h00});
        frame(0, 1, 8'h33, 3);
        push_res(0, 1, 8'h96, 1'b0, 1'b0, 4);
        run_idle(100);
        // default MAX_LEN: 65 bytes cut at 64, one byte left over
        crc_in0 = 8'h4B;
        frame(0, 0, 8'h40, 65);
        push_res(0, 0, 8'h4B, 1'b0, 1'b1, 4);
        push_res(0, 0, 8'h4B, 1'b0, 1'b0, 4);
        run_idle(300);
        // MAX_LEN = 4: 6 bytes become a 4-byte truncated frame plus a 2-byte frame
        frame(1, 0, 8'hA0, 6);
        push_res(1, 0, 8'h5A, 1'b0, 1'b1, 4);
        push_res(1, 0, 8'h5A, 1'b0, 1'b0, 4);
        run_idle(100);
        // timeout: no done ever
        dly0 = -1;
        frame(0, 0, 8'h70, 2);
        push_res(0, 0, 8'h00, 1'b1, 1'b0, 32);
        run_idle(100);
        tick();
        check("err_hold", 64'(b0.res_err), 64'(1));
        check("crc_hold", 64'(b0.res_crc), 64'(0));
        // done in the final timeout cycle wins
        dly0 = 31;
        crc_in0 = 8'h77;
        frame(0, 0, 8'h80, 3);
        push_res(0, 0, 8'h77, 1'b0, 1'b0, 32);
        run_idle(100);
        // reset after the 3rd byte of a 6-byte ch0 frame
        dly0 = 3;
        crc_in0 = 8'hE1;
        for (int i = 0; i < 6; i++) push_byte(0, 0, 8'h60 + 8'(i), i == 5, i < 3);
        exp_clr[0]++;
        for (int i = 0; i < 20 && bq[0].size() > 0; i++) tick();
        check("rst_pre_bytes", 64'(bq[0].size()), 64'(0));
        #2;
        reset_n = 1'b0;
        #1;
        chk_rst("rst_mid_d0", b0.req_ready, b0.res_valid, b0.res_crc, b0.res_err, b0.res_trunc, busy0, rstn0, en0, data0, ekey0);
        chk_rst("rst_mid_d1", b1.req_ready, b1.res_valid, b1.res_crc, b1.res_err, b1.res_trunc, busy1, rstn1, en1, data1, ekey1);
        rq[0][0].delete();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        // ch0 was served last before reset; reset must restore ch0-first
        frame(0, 0, 8'h90, 2);
        frame(0, 1, 8'hB0, 2);
        push_res(0, 0, 8'hE1, 1'b0, 1'b0, 4);
        push_res(0, 1, 8'hE1, 1'b0, 1'b0, 4);
        run_idle(100);
        check("clr_count_d0", 64'(nclr[0]), 64'(exp_clr[0]));
        check("clr_count_d1", 64'(nclr[1]), 64'(exp_clr[1]));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
